// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the MIPS pipeline control slice.
// Holds opcode/funct encodings, the 4-bit ALU operation codes, the default
// link register for jal, the decoded control bundle, and a helper that tells
// whether an opcode reads its rt field as a source register.
package mips_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (the ALU refines these itself from ALUOp 1000)
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes as produced by decode
    localparam logic [3:0] ALU_MEM   = 4'b0000;
    localparam logic [3:0] ALU_ADDI  = 4'b0001;
    localparam logic [3:0] ALU_ANDI  = 4'b0010;
    localparam logic [3:0] ALU_ORI   = 4'b0011;
    localparam logic [3:0] ALU_XORI  = 4'b0101;
    localparam logic [3:0] ALU_JAL   = 4'b0110;
    localparam logic [3:0] ALU_LUI   = 4'b0111;
    localparam logic [3:0] ALU_RTYPE = 4'b1000;

    localparam int JAL_REG_DEF = 31;

    // Decoded control bundle; link marks jal so the destination mux can pick
    // the link register.
    typedef struct packed {
        logic [3:0] aluop;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       beq;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       jump;
        logic       link;
    } ctrl_t;

    // True when the opcode reads rt as a source operand (load-use check).
    function automatic logic uses_rt(input logic [5:0] op);
        logic res;
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: res = 1'b1;
            default:                         res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main decoder.
// Ports: op   - 6-bit primary opcode of the ID instruction
//        ctrl - decoded control bundle; every field is 0 unless the opcode
//               explicitly sets it, so unknown opcodes decode to all-zero.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output ctrl_t      ctrl
);

    // Opcode to control-bundle lookup, all-zero default
    always_comb begin
        ctrl = '0;
        case (op)
            OP_RTYPE: begin
                ctrl.aluop    = ALU_RTYPE;
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_LW: begin
                ctrl.aluop    = ALU_MEM;
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_SW: begin
                ctrl.aluop    = ALU_MEM;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.beq    = 1'b1;
            end
            OP_BNE: begin
                ctrl.branch = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.aluop    = ALU_ADDI;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_ANDI: begin
                ctrl.aluop    = ALU_ANDI;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_ORI: begin
                ctrl.aluop    = ALU_ORI;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_XORI: begin
                ctrl.aluop    = ALU_XORI;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_LUI: begin
                ctrl.aluop    = ALU_LUI;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.aluop    = ALU_JAL;
                ctrl.jump     = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.link     = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control for a 5-stage MIPS core: decodes the ID instruction,
// detects load-use hazards and taken branches / jumps, and carries control
// through the ID/EX, EX/MEM and MEM/WB registers.
// Ports: clk, rst (sync, active-high)
//        id_valid, id_op, id_funct, id_rs, id_rt, id_rd - ID instruction
//        ex_br_taken - branch condition of the EX instruction
//        stall, flush - combinational hazard controls for PC / IF/ID
//        ex_*, mem_*, wb_* - registered stage control and destinations
module pipe_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int REG_AW  = 5,
    parameter int JAL_REG = JAL_REG_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [5:0]         id_op,
    input  logic [5:0]         id_funct,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_br_taken,
    output logic               stall,
    output logic               flush,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic               ex_beq,
    output logic               ex_memread,
    output logic [REG_AW-1:0]  ex_dst,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic [REG_AW-1:0]  mem_dst,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_AW-1:0]  wb_dst
);

    ctrl_t             dec_s;
    logic [REG_AW-1:0] id_dst_s;
    logic              id_regwrite_s;
    logic              hazard_s;
    logic              br_flush_s;
    logic              bubble_s;

    logic              ex_memwrite_r;
    logic              ex_memtoreg_r;
    logic              ex_regwrite_r;
    logic              mem_memtoreg_r;
    logic              mem_regwrite_r;

    // ALUOp 1000 already marks R-type; funct is resolved by the ALU itself.
    logic unused_funct_s;
    assign unused_funct_s = ^id_funct;

    ctrl_decode u_decode (
        .op   (id_op),
        .ctrl (dec_s)
    );

    // Destination select and suppression of writes to $0
    always_comb begin
        id_dst_s = id_rt;
        if (dec_s.regdst) begin
            id_dst_s = id_rd;
        end else if (dec_s.link) begin
            id_dst_s = REG_AW'(JAL_REG);
        end else begin
            id_dst_s = id_rt;
        end
        id_regwrite_s = dec_s.regwrite && (id_dst_s != {REG_AW{1'b0}});
    end

    // Hazard detection; a taken branch squashes ID so it overrides any stall,
    // and a jump waits for its own stall to clear before flushing IF/ID.
    always_comb begin
        hazard_s   = ex_memread && (ex_dst != {REG_AW{1'b0}}) && id_valid &&
                     ((ex_dst == id_rs) || (uses_rt(id_op) && (ex_dst == id_rt)));
        br_flush_s = ex_branch && ex_br_taken;
        bubble_s   = !id_valid || hazard_s || br_flush_s;
        if (rst) begin
            stall = 1'b0;
            flush = 1'b0;
        end else begin
            stall = hazard_s && !br_flush_s;
            flush = br_flush_s || (id_valid && dec_s.jump && !hazard_s);
        end
    end

    // Pipeline registers: ID/EX takes bubbles, EX/MEM and MEM/WB always advance
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_aluop       <= {ALUOP_W{1'b0}};
            ex_alusrc      <= 1'b0;
            ex_branch      <= 1'b0;
            ex_beq         <= 1'b0;
            ex_memread     <= 1'b0;
            ex_memwrite_r  <= 1'b0;
            ex_memtoreg_r  <= 1'b0;
            ex_regwrite_r  <= 1'b0;
            ex_dst         <= {REG_AW{1'b0}};
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_memtoreg_r <= 1'b0;
            mem_regwrite_r <= 1'b0;
            mem_dst        <= {REG_AW{1'b0}};
            wb_regwrite    <= 1'b0;
            wb_memtoreg    <= 1'b0;
            wb_dst         <= {REG_AW{1'b0}};
        end else begin
            if (bubble_s) begin
                ex_aluop      <= {ALUOP_W{1'b0}};
                ex_alusrc     <= 1'b0;
                ex_branch     <= 1'b0;
                ex_beq        <= 1'b0;
                ex_memread    <= 1'b0;
                ex_memwrite_r <= 1'b0;
                ex_memtoreg_r <= 1'b0;
                ex_regwrite_r <= 1'b0;
                ex_dst        <= {REG_AW{1'b0}};
            end else begin
                ex_aluop      <= ALUOP_W'(dec_s.aluop);
                ex_alusrc     <= dec_s.alusrc;
                ex_branch     <= dec_s.branch;
                ex_beq        <= dec_s.beq;
                ex_memread    <= dec_s.memread;
                ex_memwrite_r <= dec_s.memwrite;
                ex_memtoreg_r <= dec_s.memtoreg;
                ex_regwrite_r <= id_regwrite_s;
                ex_dst        <= id_dst_s;
            end
            mem_memread    <= ex_memread;
            mem_memwrite   <= ex_memwrite_r;
            mem_memtoreg_r <= ex_memtoreg_r;
            mem_regwrite_r <= ex_regwrite_r;
            mem_dst        <= ex_dst;
            wb_regwrite    <= mem_regwrite_r;
            wb_memtoreg    <= mem_memtoreg_r;
            wb_dst         <= mem_dst;
        end
    end

endmodule
